// File: rtl/eth_pkt_fifo_rd_pkg.sv
// Shared definitions for the packet-FIFO read side: FSM encoding, header
// field positions and the byte-length to word-count conversion.
package eth_pkt_fifo_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LVL,
        START,
        SEND,
        WAIT_DONE,
        DROP
    } state_t;

    localparam int LEN_LSB    = 0;
    localparam int LEN_MSB    = 15;
    localparam int WORD_CNT_W = 14;

    // Words = ceil(len/4), kept to the 14-bit width of the word counter.
    function automatic logic [WORD_CNT_W-1:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return sum[WORD_CNT_W+1:2];
    endfunction

endpackage

// File: rtl/eth_pkt_fifo_rd.sv
// Reads length-prefixed packets out of a word FIFO and feeds them to a UDP
// transmitter; empty or oversize packets are discarded and counted.
module eth_pkt_fifo_rd
    import eth_pkt_fifo_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BYTES  = 1472
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [31:0]           fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  fifo_rd_en,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    input  logic                  tx_req,
    output logic [31:0]           tx_data,
    input  logic                  tx_done,
    output logic [7:0]            drop_cnt
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

    state_t                  state;
    logic [15:0]             pkt_len;
    logic [WORD_CNT_W-1:0]   pkt_words;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [15:0]             hdr_len;
    logic [WORD_CNT_W-1:0]   hdr_words;
    logic [WORD_CNT_W-1:0]   level_ext;
    logic                    words_left;
    logic [7:0]              drop_cnt_inc;

    assign hdr_len      = fifo_rd_data[LEN_MSB:LEN_LSB];
    assign hdr_words    = len_to_words(hdr_len);
    assign level_ext    = WORD_CNT_W'(fifo_rd_water_level);
    assign words_left   = (word_cnt != pkt_words);
    assign drop_cnt_inc = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;

    // The pop strobe is combinational so the head word can be consumed on the
    // same edge that observes it; reset and an empty FIFO both veto it.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rd_rst && !fifo_empty) begin
            case (state)
                IDLE:    fifo_rd_en = 1'b1;
                SEND:    fifo_rd_en = tx_req && words_left;
                DROP:    fifo_rd_en = words_left;
                default: fifo_rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= IDLE;
            pkt_len     <= '0;
            pkt_words   <= '0;
            word_cnt    <= '0;
            drop_cnt    <= '0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
            tx_data     <= '0;
        end else begin
            tx_start_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_rd_en) begin
                        pkt_len   <= hdr_len;
                        pkt_words <= hdr_words;
                        word_cnt  <= '0;
                        if (hdr_len == 16'd0) begin
                            drop_cnt <= drop_cnt_inc;
                        end else if (hdr_len > MAX_LEN) begin
                            state <= DROP;
                        end else begin
                            state <= WAIT_LVL;
                        end
                    end
                end
                // Whole payload must already be buffered so tx_req never stalls.
                WAIT_LVL: begin
                    if (level_ext >= pkt_words) begin
                        state       <= START;
                        tx_start_en <= 1'b1;
                        tx_byte_num <= pkt_len;
                    end
                end
                START: begin
                    word_cnt <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (fifo_rd_en) begin
                        tx_data  <= fifo_rd_data;
                        word_cnt <= word_cnt + 14'd1;
                        if (word_cnt + 14'd1 == pkt_words) begin
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                // A zero word count (length wrapped the 14-bit counter) ends at once.
                DROP: begin
                    if (!words_left) begin
                        drop_cnt <= drop_cnt_inc;
                        state    <= IDLE;
                    end else if (fifo_rd_en) begin
                        word_cnt <= word_cnt + 14'd1;
                        if (word_cnt + 14'd1 == pkt_words) begin
                            drop_cnt <= drop_cnt_inc;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_pkt_fifo_rd.sv
// Directed bench for eth_pkt_fifo_rd: a simple FIFO model feeds packets and
// immediate assertions compare outputs with hand-computed values.
module tb_eth_pkt_fifo_rd;

    localparam int ADDR_WIDTH = 10;
    localparam int MAX_BYTES  = 1472;
    localparam int LW         = ADDR_WIDTH + 1;

    logic                rd_clk = 1'b0;
    logic                rd_rst;
    logic [31:0]         fifo_rd_data;
    logic                fifo_empty;
    logic [ADDR_WIDTH:0] fifo_rd_water_level;
    logic                fifo_rd_en;
    logic                tx_start_en;
    logic [15:0]         tx_byte_num;
    logic                tx_req;
    logic [31:0]         tx_data;
    logic                tx_done;
    logic [7:0]          drop_cnt;

    logic [31:0] mem [0:4095];
    int wr_ptr        = 0;
    int rd_ptr        = 0;
    int pop_cnt       = 0;
    int start_cnt     = 0;
    int empty_pop_cnt = 0;
    int checks        = 0;
    int passed        = 0;

    eth_pkt_fifo_rd #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BYTES  (MAX_BYTES)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_empty          (fifo_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .fifo_rd_en          (fifo_rd_en),
        .tx_start_en         (tx_start_en),
        .tx_byte_num         (tx_byte_num),
        .tx_req              (tx_req),
        .tx_data             (tx_data),
        .tx_done             (tx_done),
        .drop_cnt            (drop_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty          = (wr_ptr == rd_ptr);
    assign fifo_rd_data        = mem[rd_ptr[11:0]];
    assign fifo_rd_water_level = LW'(wr_ptr - rd_ptr);

    // FIFO read side shares the reset, which flushes whatever is left.
    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (fifo_rd_en && fifo_empty) empty_pop_cnt <= empty_pop_cnt + 1;
            if (fifo_rd_en && !fifo_empty) begin
                rd_ptr  <= rd_ptr + 1;
                pop_cnt <= pop_cnt + 1;
            end
            if (tx_start_en) start_cnt <= start_cnt + 1;
        end
    end

    task automatic apply_stimulus();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr[11:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_for_start(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_start_en !== 1'b1 && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_output(tag, 32'(tx_start_en), 32'd1);
    endtask

    initial begin
        rd_rst  = 1'b1;
        tx_req  = 1'b0;
        tx_done = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("rst_rd_en",    32'(fifo_rd_en),  32'd0);
        check_output("rst_start",    32'(tx_start_en), 32'd0);
        check_output("rst_byte_num", 32'(tx_byte_num), 32'd0);
        check_output("rst_tx_data",  tx_data,          32'd0);
        check_output("rst_drop_cnt", 32'(drop_cnt),    32'd0);
        rd_rst = 1'b0;
        apply_stimulus();

        $display("[TB] len=8 packet with two payload words");
        push_word(32'hABCD_0008);
        push_word(32'hA1A2_A3A4);
        push_word(32'hB1B2_B3B4);
        #1;
        check_output("idle_pop_hdr", 32'(fifo_rd_en), 32'd1);
        wait_for_start("p1_start", 10);
        check_output("p1_byte_num", 32'(tx_byte_num), 32'd8);
        apply_stimulus();
        check_output("p1_start_pulse", 32'(tx_start_en), 32'd0);
        tx_req = 1'b1;
        #1;
        check_output("p1_req_pop", 32'(fifo_rd_en), 32'd1);
        apply_stimulus();
        check_output("p1_word0", tx_data, 32'hA1A2_A3A4);
        apply_stimulus();
        check_output("p1_word1", tx_data, 32'hB1B2_B3B4);
        push_word(32'h0000_0000);
        #1;
        check_output("wait_done_no_pop", 32'(fifo_rd_en), 32'd0);
        apply_stimulus();
        apply_stimulus();
        check_output("extra_req_hold", tx_data, 32'hB1B2_B3B4);
        check_output("p1_pops", 32'(pop_cnt), 32'd3);
        tx_req  = 1'b0;
        tx_done = 1'b1;
        apply_stimulus();
        tx_done = 1'b0;
        #1;
        check_output("after_done_pop", 32'(fifo_rd_en), 32'd1);

        $display("[TB] zero-length header is discarded");
        apply_stimulus();
        check_output("len0_drop_cnt", 32'(drop_cnt), 32'd1);
        check_output("len0_pops", 32'(pop_cnt), 32'd4);
        check_output("len0_idle_empty", 32'(fifo_rd_en), 32'd0);

        $display("[TB] len=5 packet waits for its second word");
        push_word(32'h0000_0005);
        push_word(32'hC0C0_C0C0);
        apply_stimulus();
        apply_stimulus();
        tx_done = 1'b1;
        apply_stimulus();
        tx_done = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("lvl_no_start", 32'(tx_start_en), 32'd0);
        check_output("lvl_start_cnt", 32'(start_cnt), 32'd1);
        check_output("lvl_pops", 32'(pop_cnt), 32'd5);
        push_word(32'hD0D0_D0D0);
        apply_stimulus();
        check_output("p2_start", 32'(tx_start_en), 32'd1);
        check_output("p2_byte_num", 32'(tx_byte_num), 32'd5);
        apply_stimulus();
        tx_req = 1'b1;
        apply_stimulus();
        check_output("p2_word0", tx_data, 32'hC0C0_C0C0);
        apply_stimulus();
        check_output("p2_word1", tx_data, 32'hD0D0_D0D0);
        tx_req  = 1'b0;
        tx_done = 1'b1;
        apply_stimulus();
        tx_done = 1'b0;
        check_output("p2_pops", 32'(pop_cnt), 32'd7);

        $display("[TB] oversize len=1500 packet is dropped");
        push_word(32'h0000_05DC);
        for (int i = 0; i < 375; i++) push_word(32'h5500_0000 + 32'(i));
        for (int n = 0; n < 500 && drop_cnt !== 8'd2; n++) apply_stimulus();
        check_output("big_drop_cnt", 32'(drop_cnt), 32'd2);
        check_output("big_pops", 32'(pop_cnt), 32'd383);
        check_output("big_no_start", 32'(start_cnt), 32'd2);
        apply_stimulus();
        check_output("big_idle", 32'(fifo_rd_en), 32'd0);

        $display("[TB] reset asserted in the middle of SEND");
        push_word(32'h0000_0008);
        push_word(32'hE1E2_E3E4);
        push_word(32'hF1F2_F3F4);
        wait_for_start("p3_start", 10);
        apply_stimulus();
        tx_req = 1'b1;
        apply_stimulus();
        check_output("p3_word0", tx_data, 32'hE1E2_E3E4);
        check_output("p3_req_pop", 32'(fifo_rd_en), 32'd1);
        rd_rst = 1'b1;
        #1;
        check_output("mid_rst_rd_en",    32'(fifo_rd_en),  32'd0);
        check_output("mid_rst_tx_data",  tx_data,          32'd0);
        check_output("mid_rst_byte_num", 32'(tx_byte_num), 32'd0);
        check_output("mid_rst_start",    32'(tx_start_en), 32'd0);
        check_output("mid_rst_drop_cnt", 32'(drop_cnt),    32'd0);
        tx_req = 1'b0;
        apply_stimulus();
        rd_rst = 1'b0;
        apply_stimulus();
        apply_stimulus();
        check_output("post_rst_idle", 32'(fifo_rd_en), 32'd0);
        check_output("post_rst_start", 32'(tx_start_en), 32'd0);
        check_output("never_pop_empty", 32'(empty_pop_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
